// File: rtl/dmem_hs_pkg.sv
// dmem_hs_pkg: shared types and constants for the handshaked data memory
package dmem_hs_pkg;
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;
  typedef struct packed {
    logic        we;
    size_e       size;
    logic        uns;
    logic [31:0] addr;
  } req_t;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;
endpackage

// File: rtl/dmem_hs_array.sv
// dmem_hs_array: zero-initialised word storage, byte-enabled synchronous write, combinational read
module dmem_hs_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  // write only the enabled byte lanes; untouched lanes keep their contents
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < DATA_W/8; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/dmem_hs.sv
// dmem_hs: valid/ready data memory with fixed latency, error checks; byte/half access with DMEM_HS_SUBWORD_EN
module dmem_hs
  import dmem_hs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024,
  parameter int LATENCY = 2,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int NB = DATA_W/8;
  localparam int LB = $clog2(NB);
  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH*NB);
  localparam logic [DATA_W-1:0] WMASK = DATA_W'(64'hFFFF_FFFF);
  localparam logic [2:0] CNT0 = 3'(LATENCY > 1 ? LATENCY-2 : 0);
  state_e            st;
  logic [2:0]        cnt;
  req_t              r, c;
  logic [DATA_W-1:0] r_wdata, c_wdata, rd, raw, ld;
  logic [31:0]       off;
  logic [LB-1:0]     lane;
  logic [NB-1:0]     be;
  logic              accept, fire, mis, oor, size_err, err;
  assign req_ready = st == ST_IDLE && !rst;
  assign accept = req_valid && req_ready;
  assign rsp_valid = st == ST_RESP;
  assign fire = LATENCY == 1 ? accept : st == ST_BUSY && cnt == '0;
  assign c = LATENCY == 1 ? req_t'{we: req_we, size: size_e'(req_size), uns: req_unsigned, addr: req_addr} : r;
  assign c_wdata = LATENCY == 1 ? req_wdata : r_wdata;
  assign off = c.addr - BASE_ADDR;
  assign lane = off[LB-1:0];
  assign mis = (c.size == SZ_HALF && c.addr[0]) || (c.size == SZ_WORD && c.addr[1:0] != '0);
  assign oor = c.addr < BASE_ADDR || {1'b0, off} >= SPAN;
`ifdef DMEM_HS_SUBWORD_EN
  assign size_err = c.size == SZ_RSVD;
`else
  assign size_err = c.size != SZ_WORD;
`endif
  assign err = mis || oor || size_err;
  assign be = (c.size == SZ_BYTE ? NB'(1) : c.size == SZ_HALF ? NB'(3) : NB'(15)) << lane;
  assign raw = rd >> {lane, 3'b000};
  assign ld = c.size == SZ_BYTE ? {{(DATA_W-8){~c.uns & raw[7]}}, raw[7:0]} :
              c.size == SZ_HALF ? {{(DATA_W-16){~c.uns & raw[15]}}, raw[15:0]} : raw & WMASK;
  dmem_hs_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (fire && c.we && !err),
    .be    (be),
    .addr  (off[LB +: AW]),
    .wdata (c_wdata << {lane, 3'b000}),
    .rdata (rd)
  );
  // capture the request, count down BUSY, latch the response on entry to RESP
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= ST_IDLE;
      cnt <= '0;
      r <= '0;
      r_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (accept) begin
        r <= req_t'{we: req_we, size: size_e'(req_size), uns: req_unsigned, addr: req_addr};
        r_wdata <= req_wdata;
        cnt <= CNT0;
      end else if (st == ST_BUSY) cnt <= cnt - 3'd1;
      if (fire) begin
        rsp_rdata <= err || c.we ? '0 : ld;
        rsp_err <= err;
      end
      st <= fire ? ST_RESP : accept ? ST_BUSY : st == ST_RESP && rsp_ready ? ST_IDLE : st;
    end
endmodule

// File: tb/tb_dmem_hs.sv
// tb_dmem_hs: directed self-checking bench for dmem_hs (DATA_W=32, LATENCY=2)
module tb_dmem_hs;
  localparam logic [31:0] A = 32'h1001_0000;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;
`ifdef DMEM_HS_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_we = 0, req_unsigned = 0;
  logic [31:0] req_addr = '0, req_wdata = '0, rsp_rdata;
  logic [1:0] req_size = W;
  logic rsp_valid, rsp_ready = 1, rsp_err;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  dmem_hs dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic xact(input string tag, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [1:0] sz, input logic uns, input logic [31:0] exp_d, input logic exp_e);
    int n;
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_size = sz; req_unsigned = uns;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, ".rdy"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = 0;
    n = 1;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, ".lat"}, n, 32'd2);
    chk({tag, ".data"}, rsp_rdata, exp_d);
    chk({tag, ".err"}, {31'b0, rsp_err}, {31'b0, exp_e});
    @(posedge clk); #1;
  endtask
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", {31'b0, req_ready}, 32'd0);
    chk("rst.valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst.data", rsp_rdata, 32'd0);
    chk("rst.err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk) rst = 0;
    #1 chk("rst.rel_ready", {31'b0, req_ready}, 32'd1);
    xact("st_w", 1, A + 4, 32'hDEAD_BEEF, W, 0, 32'h0, 0);
    xact("ld_w", 0, A + 4, 32'h0, W, 0, 32'hDEAD_BEEF, 0);
    xact("st_b", 1, A + 9, 32'h80, B, 0, 32'h0, !SUB);
    xact("ld_bs", 0, A + 9, 32'h0, B, 0, SUB ? 32'hFFFF_FF80 : 32'h0, !SUB);
    xact("ld_bu", 0, A + 9, 32'h0, B, 1, SUB ? 32'h0000_0080 : 32'h0, !SUB);
    xact("ld_w8", 0, A + 8, 32'h0, W, 0, SUB ? 32'h0000_8000 : 32'h0, 0);
    xact("st_h", 1, A + 14, 32'hBEEF, H, 0, 32'h0, !SUB);
    xact("ld_wc", 0, A + 12, 32'h0, W, 0, SUB ? 32'hBEEF_0000 : 32'h0, 0);
    xact("ld_hs", 0, A + 14, 32'h0, H, 0, SUB ? 32'hFFFF_BEEF : 32'h0, !SUB);
    xact("mis_w", 0, A + 2, 32'h0, W, 0, 32'h0, 1);
    xact("st_w0", 1, A, 32'h1122_3344, W, 0, 32'h0, 0);
    xact("mis_h", 1, A + 3, 32'hAAAA, H, 0, 32'h0, 1);
    xact("ld_w0", 0, A, 32'h0, W, 0, 32'h1122_3344, 0);
    xact("low", 0, 32'h0FFF_FFFC, 32'h0, W, 0, 32'h0, 1);
    xact("high", 0, A + 32'h1000, 32'h0, W, 0, 32'h0, 1);
    xact("last", 0, A + 32'hFFC, 32'h0, W, 0, 32'h0, 0);
    xact("rsvd", 0, A, 32'h0, R, 0, 32'h0, 1);
    xact("ld_b0", 0, A, 32'h0, B, 0, SUB ? 32'h44 : 32'h0, !SUB);
    // stalled response with the request line held and its fields changed
    @(negedge clk);
    rsp_ready = 0; req_valid = 1; req_we = 0; req_addr = A + 4; req_size = W;
    @(posedge clk); #1;
    req_we = 1; req_wdata = 32'h5555_5555;
    n = 1;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("stall.lat", n, 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("stall.valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall.data", rsp_rdata, 32'hDEAD_BEEF);
      chk("stall.ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk) begin rsp_ready = 1; req_valid = 0; end
    @(posedge clk); #1;
    chk("stall.done_valid", {31'b0, rsp_valid}, 32'd0);
    chk("stall.done_ready", {31'b0, req_ready}, 32'd1);
    xact("stall.mem", 0, A + 4, 32'h0, W, 0, 32'hDEAD_BEEF, 0);
    // reset during BUSY aborts a store
    xact("rs_st", 1, A + 16, 32'h1234_5678, W, 0, 32'h0, 0);
    xact("rs_ld", 0, A + 16, 32'h0, W, 0, 32'h1234_5678, 0);
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = A + 16; req_wdata = 32'hFFFF_FFFF; req_size = W;
    @(posedge clk); #1 req_valid = 0;
    chk("rs.busy_data", rsp_rdata, 32'h1234_5678);
    #2 rst = 1;
    #1;
    chk("rs.valid", {31'b0, rsp_valid}, 32'd0);
    chk("rs.ready", {31'b0, req_ready}, 32'd0);
    chk("rs.data", rsp_rdata, 32'd0);
    chk("rs.err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk) rst = 0;
    #1 chk("rs.rel_ready", {31'b0, req_ready}, 32'd1);
    xact("rs_chk", 0, A + 16, 32'h0, W, 0, 32'h1234_5678, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_hs.md
DMEM_HS -- requirements
Module: dmem_hs

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits (multiple of 8, max 64).
REQ-002 SHALL have parameter DEPTH, default 1024, number of DATA_W words stored.
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request accept to response (legal 1..8).
REQ-004 SHALL have parameter BASE_ADDR, default 32'h10010000, byte address of word 0.
REQ-005 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port req_valid, input, 1, request present.
REQ-008 SHALL have port req_ready, output, 1, block can accept a request.
REQ-009 SHALL have port req_we, input, 1, 1=store, 0=load.
REQ-010 SHALL have port req_addr, input, 32, byte address.
REQ-011 SHALL have port req_wdata, input, DATA_W, store data, LSB-aligned for sub-word stores.
REQ-012 SHALL have port req_size, input, 2, 00=byte, 01=half, 10=word, 11=reserved (treated as error).
REQ-013 SHALL have port req_unsigned, input, 1, zero-extend sub-word loads when 1, sign-extend when 0.
REQ-014 SHALL have port rsp_valid, output, 1, response present.
REQ-015 SHALL have port rsp_ready, input, 1, consumer accepts response.
REQ-016 SHALL have port rsp_rdata, output, DATA_W, load data, extended per size and signedness.
REQ-017 SHALL have port rsp_err, output, 1, request was misaligned, out of range or reserved size.

Function
REQ-018 SHALL accept a request on a rising edge where req_valid && req_ready; all request fields are registered at that edge.
REQ-019 SHALL implement FSM IDLE->BUSY->RESP->IDLE; req_ready=1 only in IDLE with rst low.
REQ-020 SHALL assert rsp_valid exactly LATENCY cycles after the accept edge; with LATENCY=1, BUSY lasts zero cycles and the FSM goes IDLE->RESP.
REQ-021 SHALL perform the memory read/write on the edge entering RESP, never earlier.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1; return to IDLE on that edge.
REQ-023 SHALL ignore req_valid outside IDLE; back-to-back throughput is one request per LATENCY+1 cycles minimum.
REQ-024 SHALL flag error if: half with addr[0]!=0; word with addr[1:0]!=0; addr < BASE_ADDR; addr >= BASE_ADDR+DEPTH*DATA_W/8; or size=11.
REQ-025 SHALL, on error, suppress any write, drive rsp_rdata=0 and rsp_err=1, with unchanged latency.
REQ-026 SHALL index word (addr-BASE_ADDR)>>log2(DATA_W/8) and select byte lanes from the low address bits.
REQ-027 SHALL, for stores, write only the addressed byte lanes; other lanes keep their value.
REQ-028 SHALL, for store responses, drive rsp_rdata=0.
REQ-029 SHALL initialise every array word to 0 at time zero; reset does not alter array contents.

Reset
REQ-030 SHALL, while rst=1, force state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 immediately, without a clock edge.
REQ-031 SHALL abort any request in BUSY on reset with no write performed; req_ready=1 on the first cycle after rst falls.

Configuration
REQ-032 SHALL, with DMEM_HS_SUBWORD_EN defined, support byte and half accesses per REQ-012/013/027.
REQ-033 SHALL, without DMEM_HS_SUBWORD_EN, treat req_size=00 or 01 as error per REQ-025 and ignore req_unsigned.

Structure
REQ-034 SHALL place the size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD), the FSM state enum and the default BASE_ADDR constant in package dmem_hs_pkg.
REQ-035 SHALL isolate storage in sub-module dmem_hs_array (synchronous write with per-byte enables, read port, zero-initialised).

Verification (DATA_W=32, LATENCY=2, BASE_ADDR=0x10010000, DMEM_HS_SUBWORD_EN defined unless stated)
REQ-036 SHALL cover: store word 0xDEADBEEF @0x10010004, then load word -> rdata 0xDEADBEEF, err=0, rsp_valid exactly 2 cycles after each accept.
REQ-037 SHALL cover: store byte 0x80 @0x10010009; signed byte load -> 0xFFFFFF80; unsigned byte load -> 0x00000080; word load @0x10010008 -> 0x00008000.
REQ-038 SHALL cover: word load @0x10010002 -> err=1, rdata 0; half store @0x10010003 -> err=1 and a later word load @0x10010000 is unchanged; load @0x0FFFFFFC and @0x10011000 -> err=1.
REQ-039 SHALL cover: rsp_ready held low 5 cycles with req_valid held high -> rsp_valid and data stable, req_ready=0, no second request accepted.
REQ-040 SHALL cover: store 0x12345678 @0x10010010, then store 0xFFFFFFFF there with rst pulsed during BUSY -> outputs zero immediately and a later load returns 0x12345678.
REQ-041 SHALL cover: without DMEM_HS_SUBWORD_EN, byte load @0x10010000 -> err=1, rdata 0.
